// File: rtl/main_decoder.sv
// Main control decoder for the single-cycle LEGv8 core: opcode to datapath controls
// plus exception status for invalid opcodes and external interrupts.
module main_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] Op,
    input  logic        ExtIRQ,
    output logic        Reg2Loc,
    output logic [1:0]  ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic [1:0]  ALUOp,
    output logic        ERet,
    output logic        Exc,
    output logic        ExtIAck,
    output logic [3:0]  EStatus
);

    localparam logic [3:0] ESTAT_NONE = 4'b0000;
    localparam logic [3:0] ESTAT_IRQ  = 4'b0001;
    localparam logic [3:0] ESTAT_INV  = 4'b0010;

    // Decode is stateless; the clock is present only for interface uniformity.
    logic unused_clk;
    assign unused_clk = clk;

    logic       dec_valid;
    logic       dec_r2l;
    logic [1:0] dec_alusrc;
    logic       dec_mtr;
    logic       dec_rw;
    logic       dec_mr;
    logic       dec_mw;
    logic       dec_br;
    logic [1:0] dec_aluop;
    logic       dec_eret;

    always_comb begin
        dec_valid  = 1'b1;
        dec_r2l    = 1'b0;
        dec_alusrc = 2'b00;
        dec_mtr    = 1'b0;
        dec_rw     = 1'b0;
        dec_mr     = 1'b0;
        dec_mw     = 1'b0;
        dec_br     = 1'b0;
        dec_aluop  = 2'b00;
        dec_eret   = 1'b0;
        casez (Op)
            11'b11111000010: begin // LDUR
                dec_alusrc = 2'b01;
                dec_mtr    = 1'b1;
                dec_rw     = 1'b1;
                dec_mr     = 1'b1;
            end
            11'b11111000000: begin // STUR
                dec_r2l    = 1'b1;
                dec_alusrc = 2'b01;
                dec_mw     = 1'b1;
            end
            11'b10110100???: begin // CBZ
                dec_r2l   = 1'b1;
                dec_br    = 1'b1;
                dec_aluop = 2'b01;
            end
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: begin // ADD, SUB, AND, ORR
                dec_rw    = 1'b1;
                dec_aluop = 2'b10;
            end
            11'b1001000100?, 11'b1101000100?: begin // ADDI, SUBI
                dec_alusrc = 2'b01;
                dec_rw     = 1'b1;
                dec_aluop  = 2'b10;
            end
            11'b11010101001: begin // MRS
                dec_r2l    = 1'b1;
                dec_alusrc = 2'b10;
                dec_rw     = 1'b1;
                dec_aluop  = 2'b01;
            end
            11'b11010110100: begin // ERET: Branch redirects PC to the saved link
                dec_br    = 1'b1;
                dec_aluop = 2'b01;
                dec_eret  = 1'b1;
            end
            default: dec_valid = 1'b0;
        endcase
        // casez treats Z as a wildcard, so an undriven Op could otherwise match
        if ($isunknown(Op)) begin
            dec_valid = 1'b0;
        end
        if (!dec_valid) begin
            dec_r2l    = 1'b0;
            dec_alusrc = 2'b00;
            dec_mtr    = 1'b0;
            dec_rw     = 1'b0;
            dec_mr     = 1'b0;
            dec_mw     = 1'b0;
            dec_br     = 1'b0;
            dec_aluop  = 2'b00;
            dec_eret   = 1'b0;
        end
    end

    // Reset gates every output combinationally; invalid opcode outranks the IRQ.
    always_comb begin
        Reg2Loc  = 1'b0;
        ALUSrc   = 2'b00;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Branch   = 1'b0;
        ALUOp    = 2'b00;
        ERet     = 1'b0;
        Exc      = 1'b0;
        ExtIAck  = 1'b0;
        EStatus  = ESTAT_NONE;
        if (!reset) begin
            Reg2Loc  = dec_r2l;
            ALUSrc   = dec_alusrc;
            MemtoReg = dec_mtr;
            RegWrite = dec_rw;
            MemRead  = dec_mr;
            MemWrite = dec_mw;
            Branch   = dec_br;
            ALUOp    = dec_aluop;
            ERet     = dec_eret;
            if (!dec_valid) begin
                Exc     = 1'b1;
                EStatus = ESTAT_INV;
            end else if (ExtIRQ) begin
                Exc     = 1'b1;
                ExtIAck = 1'b1;
                EStatus = ESTAT_IRQ;
            end
        end
    end

endmodule

// File: tb/tb_main_decoder.sv
// Directed table-driven bench for main_decoder, plus an asynchronous reset sequence.
module tb_main_decoder;

    logic        clk;
    logic        reset;
    logic [10:0] Op;
    logic        ExtIRQ;
    logic        Reg2Loc;
    logic [1:0]  ALUSrc;
    logic        MemtoReg;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        Branch;
    logic [1:0]  ALUOp;
    logic        ERet;
    logic        Exc;
    logic        ExtIAck;
    logic [3:0]  EStatus;

    main_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .ExtIRQ   (ExtIRQ),
        .Reg2Loc  (Reg2Loc),
        .ALUSrc   (ALUSrc),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .ALUOp    (ALUOp),
        .ERet     (ERet),
        .Exc      (Exc),
        .ExtIAck  (ExtIAck),
        .EStatus  (EStatus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word layout: {r2l, ALUSrc[1:0], mtr, rw, mr, mw, br, ALUOp[1:0], ERet, Exc, ExtIAck, EStatus[3:0]}
    typedef struct {
        string       name;
        logic        rst;
        logic [10:0] op;
        logic        irq;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [16:0] actual();
        return {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch,
                ALUOp, ERet, Exc, ExtIAck, EStatus};
    endfunction

    task automatic check(input string name, input logic [16:0] exp);
        logic [16:0] act;
        act = actual();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic r, input logic [10:0] o,
                       input logic i, input logic [16:0] e);
        vec_t v;
        v.name = n; v.rst = r; v.op = o; v.irq = i; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        add("reset_ldur_irq", 1, 11'b11111000010, 1, 17'b0_00_0_0_0_0_0_00_0_0_0_0000);
        add("ldur",           0, 11'b11111000010, 0, 17'b0_01_1_1_1_0_0_00_0_0_0_0000);
        add("stur",           0, 11'b11111000000, 0, 17'b1_01_0_0_0_1_0_00_0_0_0_0000);
        add("cbz_000",        0, 11'b10110100000, 0, 17'b1_00_0_0_0_0_1_01_0_0_0_0000);
        add("cbz_111",        0, 11'b10110100111, 0, 17'b1_00_0_0_0_0_1_01_0_0_0_0000);
        add("add",            0, 11'b10001011000, 0, 17'b0_00_0_1_0_0_0_10_0_0_0_0000);
        add("sub",            0, 11'b11001011000, 0, 17'b0_00_0_1_0_0_0_10_0_0_0_0000);
        add("and",            0, 11'b10001010000, 0, 17'b0_00_0_1_0_0_0_10_0_0_0_0000);
        add("orr",            0, 11'b10101010000, 0, 17'b0_00_0_1_0_0_0_10_0_0_0_0000);
        add("addi_0",         0, 11'b10010001000, 0, 17'b0_01_0_1_0_0_0_10_0_0_0_0000);
        add("addi_1",         0, 11'b10010001001, 0, 17'b0_01_0_1_0_0_0_10_0_0_0_0000);
        add("subi",           0, 11'b11010001000, 0, 17'b0_01_0_1_0_0_0_10_0_0_0_0000);
        add("mrs",            0, 11'b11010101001, 0, 17'b1_10_0_1_0_0_0_01_0_0_0_0000);
        add("eret",           0, 11'b11010110100, 0, 17'b0_00_0_0_0_0_1_01_1_0_0_0000);
        add("inv_zero",       0, 11'b00000000000, 0, 17'b0_00_0_0_0_0_0_00_0_1_0_0010);
        add("inv_zero_irq",   0, 11'b00000000000, 1, 17'b0_00_0_0_0_0_0_00_0_1_0_0010);
        add("inv_near_ldur",  0, 11'b11111000011, 0, 17'b0_00_0_0_0_0_0_00_0_1_0_0010);
        add("inv_near_cbz",   0, 11'b10110101000, 0, 17'b0_00_0_0_0_0_0_00_0_1_0_0010);
        add("add_irq",        0, 11'b10001011000, 1, 17'b0_00_0_1_0_0_0_10_0_1_1_0001);
        add("stur_irq",       0, 11'b11111000000, 1, 17'b1_01_0_0_0_1_0_00_0_1_1_0001);
        add("eret_irq",       0, 11'b11010110100, 1, 17'b0_00_0_0_0_0_1_01_1_1_1_0001);

        reset = 1'b1; Op = '0; ExtIRQ = 1'b0;
        @(posedge clk); #1;
        check("reset_state", 17'b0);

        foreach (vecs[k]) begin
            @(negedge clk);
            reset = vecs[k].rst; Op = vecs[k].op; ExtIRQ = vecs[k].irq;
            @(posedge clk); #1;
            check(vecs[k].name, vecs[k].exp);
        end

        // Reset between clock edges must clear outputs without waiting for clk.
        @(negedge clk);
        reset = 1'b0; Op = 11'b11111000010; ExtIRQ = 1'b1;
        #1;
        check("pre_async_ldur_irq", 17'b0_01_1_1_1_0_0_00_0_1_1_0001);
        #1 reset = 1'b1;
        #1;
        check("async_reset_assert", 17'b0);
        #1 reset = 1'b0;
        #1;
        check("async_reset_release", 17'b0_01_1_1_1_0_0_00_0_1_1_0001);
        ExtIRQ = 1'b0;
        #1;
        check("irq_drop_comb", 17'b0_01_1_1_1_0_0_00_0_0_0_0000);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_decoder.md
Name: main_decoder

Overview:
Main control decoder for the single-cycle LEGv8 processor. It maps the 11-bit instruction opcode field to datapath control signals: register-read select, ALU operand source, memory and write-back controls, branch, ALU operation class and exception-return. It also reports exception status for invalid opcodes and external interrupts. It sits between instruction fetch (Instr[31:21]) and the datapath, ALU decoder and exception logic.

Parameters:
None.

Ports:
clk  input  1  system clock; one clock domain; decode path does not use it (no internal state)
reset  input  1  asynchronous, active-high; forces every output to 0 while high
Op  input  11  instruction opcode field Instr[31:21]
ExtIRQ  input  1  external interrupt request, level; tie 0 when unused
Reg2Loc  output  1  1 selects Rt (Instr[4:0]) as second read register; 0 selects Rm
ALUSrc  output  2  00 register, 01 sign-extended immediate, 10 system register (MRS)
MemtoReg  output  1  write-back from data memory
RegWrite  output  1  register file write enable
MemRead  output  1  data memory read
MemWrite  output  1  data memory write
Branch  output  1  conditional branch (CBZ)
ALUOp  output  2  00 add (address), 01 pass-B/zero test, 10 R-type function decode
ERet  output  1  exception return
Exc  output  1  exception raised this instruction
ExtIAck  output  1  external interrupt acknowledge
EStatus  output  4  exception cause: 0000 none, 0001 external IRQ, 0010 invalid opcode

Behaviour:
- Purely combinational from Op/ExtIRQ to the outputs; reset gates the outputs asynchronously. Zero latency; outputs settle within the same cycle.
- reset=1: all outputs 0, independent of Op and ExtIRQ.
- Decode table (r2l, ALUSrc, mtr, rw, mr, mw, br, ERet, ALUOp):
  - LDUR 11111000010: 0,01,1,1,1,0,0,0,00
  - STUR 11111000000: 1,01,0,0,0,1,0,0,00
  - CBZ 10110100xxx: 1,00,0,0,0,0,1,0,01
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: 0,00,0,1,0,0,0,0,10
  - ADDI 1001000100x, SUBI 1101000100x: 0,01,0,1,0,0,0,0,10
  - MRS 11010101001: 1,10,0,1,0,0,0,0,01
  - ERET 11010110100: 0,00,0,0,0,0,1,1,01 (Branch=1 redirects PC to the saved exception link register)
- Invalid opcode (no table match, including X/Z on Op): all datapath controls 0, Exc=1, EStatus=0010.
- ExtIRQ=1 with a valid opcode: datapath controls per table, Exc=1, ExtIAck=1, EStatus=0001.
- ExtIRQ=1 with an invalid opcode: invalid opcode takes priority. EStatus=0010, Exc=1, ExtIAck=0; the IRQ stays pending to the source.
- Valid opcode, ExtIRQ=0: Exc=0, ExtIAck=0, EStatus=0000.
- Don't-care bits (x above) are matched with casez; no latches; a default branch is mandatory.

Test Plan:
- reset=0, ExtIRQ=0, Op=11111000010 (LDUR) -> Reg2Loc=0, ALUSrc=01, MemtoReg=1, RegWrite=1, MemRead=1, MemWrite=0, Branch=0, ERet=0, ALUOp=00, EStatus=0000.
- Op=11111000000 (STUR) -> 1,01,0,0,0,1,0,0,00, EStatus=0000. Op=10110100000 (CBZ) -> 1,00,0,0,0,0,1,0,01.
- Op in {10001011000, 11001011000, 10001010000, 10101010000} -> 0,00,0,1,0,0,0,0,10, EStatus=0000 for each.
- Op=10010001000 (ADDI) -> ALUSrc=01, RegWrite=1, ALUOp=10. Op=11010110100 (ERET) -> ERet=1, Branch=1. Op=11010101001 (MRS) -> ALUSrc=10, RegWrite=1.
- Op=00000000000 -> all controls 0, Exc=1, EStatus=0010. Same Op with ExtIRQ=1 -> EStatus=0010, ExtIAck=0.
- ADD with ExtIRQ=1 -> RegWrite=1, Exc=1, ExtIAck=1, EStatus=0001. Assert reset mid-sequence without a clock edge -> all outputs 0 immediately; deassert -> outputs return to decoded values.
